// File: rtl/mem_initiator_pkg.sv
// Shared types for the memory initiator: RAM transfer sizes, FSM states and the captured request.
package mem_initiator_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        DT_BYTE  = 2'b00,
        DT_HALF  = 2'b01,
        DT_WORD  = 2'b10,
        DT_DWORD = 2'b11
    } data_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_WAIT    = 2'b10,
        ST_RELEASE = 2'b11
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        data_type_e        size;
        logic              sign;
        logic [DATA_W-1:0] wr_lo;
    } req_t;

    // Store data is zero-padded above the transfer size.
    function automatic logic [DATA_W-1:0] store_data(input data_type_e size,
                                                     input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] res;
        case (size)
            DT_BYTE: res = {24'b0, data[7:0]};
            DT_HALF: res = {16'b0, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_initiator_load_extend.sv
// Load alignment: picks the low byte/half of the RAM word and zero- or sign-extends it.
module mem_load_extend
    import mem_initiator_pkg::*;
(
    input  logic [DATA_W-1:0] raw,
    input  data_type_e        size,
    input  logic              sign,
    output logic [DATA_W-1:0] result_c
);

    always_comb begin
        result_c = raw;
        case (size)
            DT_BYTE: result_c = {{24{sign & raw[7]}}, raw[7:0]};
            DT_HALF: result_c = {{16{sign & raw[15]}}, raw[15:0]};
            default: result_c = raw;
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// Memory initiator: runs one load/store (two word beats for doubleword) over a MOV/MOC handshake.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int unsigned MIN_HOLD = 1,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [1:0]        Size,
    input  logic              Signed,
    input  logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] WrDataHi,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [DATA_W-1:0] RdData,
    output logic [DATA_W-1:0] RdDataHi,
    output logic              MOV,
    output logic              ReadWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [1:0]        DataType,
    output logic [DATA_W-1:0] MemDataIn,
    input  logic              MOC,
    input  logic [DATA_W-1:0] MemDataOut
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic              beat_q, beat_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DATA_W-1:0] hi_stage_q, hi_stage_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              mov_q, mov_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    data_type_e        dt_q, dt_d;
    logic [DATA_W-1:0] mem_in_q, mem_in_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] rd_hi_q, rd_hi_d;

    logic [DATA_W-1:0] load_c;
    data_type_e        start_size_c;
    logic              last_beat_c;

    mem_load_extend u_extend (
        .raw      (MemDataOut),
        .size     (req_q.size),
        .sign     (req_q.sign),
        .result_c (load_c)
    );

    assign start_size_c = data_type_e'(Size);
    assign last_beat_c  = (req_q.size != DT_DWORD) || beat_q;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        beat_d     = beat_q;
        hold_d     = hold_q;
        wait_d     = wait_q;
        hi_stage_d = hi_stage_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        rw_d       = rw_q;
        addr_d     = addr_q;
        dt_d       = dt_q;
        mem_in_d   = mem_in_q;
        rd_d       = rd_q;
        rd_hi_d    = rd_hi_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d  = ST_ASSERT;
                    req_d    = '{write: Write, addr: Addr, size: start_size_c,
                                 sign: Signed, wr_lo: WrData};
                    beat_d   = 1'b0;
                    hold_d   = '0;
                    rw_d     = ~Write;
                    addr_d   = Addr;
                    dt_d     = (start_size_c == DT_DWORD) ? DT_WORD : start_size_c;
                    mem_in_d = (start_size_c == DT_DWORD) ? WrDataHi
                                                          : store_data(start_size_c, WrData);
                end
            end
            ST_ASSERT: begin
                if (hold_q == HOLD_W'(MIN_HOLD - 1)) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_WAIT: begin
                if (MOC) begin
                    state_d = ST_RELEASE;
                    // Results commit only on the final beat so an abort leaves them untouched.
                    if (last_beat_c) begin
                        done_d = 1'b1;
                        if (!req_q.write) begin
                            rd_d = load_c;
                            if (req_q.size == DT_DWORD) begin
                                rd_hi_d = hi_stage_q;
                            end
                        end
                    end else begin
                        hi_stage_d = MemDataOut;
                    end
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!last_beat_c) begin
                    state_d  = ST_ASSERT;
                    beat_d   = 1'b1;
                    hold_d   = '0;
                    addr_d   = req_q.addr + ADDR_W'(4);
                    mem_in_d = req_q.wr_lo;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mov_d  = (state_d == ST_ASSERT) || (state_d == ST_WAIT);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            beat_q     <= 1'b0;
            hold_q     <= '0;
            wait_q     <= '0;
            hi_stage_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            mov_q      <= 1'b0;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            dt_q       <= DT_BYTE;
            mem_in_q   <= '0;
            rd_q       <= '0;
            rd_hi_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            beat_q     <= beat_d;
            hold_q     <= hold_d;
            wait_q     <= wait_d;
            hi_stage_q <= hi_stage_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            mov_q      <= mov_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            dt_q       <= dt_d;
            mem_in_q   <= mem_in_d;
            rd_q       <= rd_d;
            rd_hi_q    <= rd_hi_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = error_q;
    assign MOV       = mov_q;
    assign ReadWrite = rw_q;
    assign Address   = addr_q;
    assign DataType  = dt_q;
    assign MemDataIn = mem_in_q;
    assign RdData    = rd_q;
    assign RdDataHi  = rd_hi_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: directed transactions, scoreboard checked on every Done/Error pulse.
module tb_mem_initiator;

    logic        Clk = 1'b0;
    logic        Reset, Start, Write, Signed, MOC;
    logic [7:0]  Addr;
    logic [1:0]  Size;
    logic [31:0] WrData, WrDataHi, MemDataOut;
    logic        Busy, Done, Error, MOV, ReadWrite;
    logic [31:0] RdData, RdDataHi, MemDataIn;
    logic [7:0]  Address;
    logic [1:0]  DataType;
    logic [31:0] mem_a, mem_b;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
        logic [31:0] hi;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_initiator #(.MIN_HOLD(1), .TIMEOUT(15)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Write      (Write),
        .Addr       (Addr),
        .Size       (Size),
        .Signed     (Signed),
        .WrData     (WrData),
        .WrDataHi   (WrDataHi),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error),
        .RdData     (RdData),
        .RdDataHi   (RdDataHi),
        .MOV        (MOV),
        .ReadWrite  (ReadWrite),
        .Address    (Address),
        .DataType   (DataType),
        .MemDataIn  (MemDataIn),
        .MOC        (MOC),
        .MemDataOut (MemDataOut)
    );

    always #5 Clk = ~Clk;

    // RAM model: address 0x02 returns mem_b, every other address mem_a.
    assign MemDataOut = (Address == 8'h02) ? mem_b : mem_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Start is sampled at the next rising edge; returns at the negedge of cycle 1.
    task automatic issue(input logic w, input logic [7:0] a, input logic [1:0] s,
                         input logic sg, input logic [31:0] wd, input logic [31:0] wdh);
        Write = w; Addr = a; Size = s; Signed = sg; WrData = wd; WrDataHi = wdh;
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_mov", MOV, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_error", Error, 0);
        chk("rst_address", Address, 0);
        chk("rst_datatype", DataType, 0);
        chk("rst_memdatain", MemDataIn, 0);
        chk("rst_readwrite", ReadWrite, 1);
        chk("rst_rddata", RdData, 0);
        chk("rst_rddatahi", RdDataHi, 0);
    endtask

    // Single-beat transaction with MOC high: bus checked in cycle 1, Done expected in cycle 3.
    task automatic single(input logic w, input logic [7:0] a, input logic [1:0] s,
                          input logic sg, input logic [31:0] wd, input logic [31:0] mdi,
                          input exp_t e);
        sb.push_back(e);
        issue(w, a, s, sg, wd, 32'h0);
        chk("c1_mov", MOV, 1);
        chk("c1_readwrite", ReadWrite, {31'b0, ~w});
        chk("c1_address", Address, {24'b0, a});
        chk("c1_datatype", DataType, {30'b0, s});
        chk("c1_memdatain", MemDataIn, mdi);
        step(1);
        chk("c2_mov", MOV, 1);
        step(1);
        chk("c3_done", Done, 1);
        chk("c3_mov", MOV, 0);
        chk("c3_busy", Busy, 1);
        step(1);
        chk("c4_busy", Busy, 0);
    endtask

    // Scoreboard monitor: every completion or abort pops one expected record.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Reset === 1'b0 && (Done === 1'b1 || Error === 1'b1)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: Done=%b Error=%b with no pending record", Done, Error);
            end else begin
                e = sb.pop_front();
                chk("sb_error", {31'b0, Error}, {31'b0, e.err});
                chk("sb_done", {31'b0, Done}, {31'b0, ~e.err});
                chk("sb_rddata", RdData, e.rd);
                chk("sb_rddatahi", RdDataHi, e.hi);
            end
        end
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Write = 1'b0; Addr = '0; Size = '0; Signed = 1'b0;
        WrData = '0; WrDataHi = '0; MOC = 1'b1; mem_a = '0; mem_b = '0;
        step(2);
        chk_reset();
        Reset = 1'b0;

        single(1'b1, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, '{1'b0, 32'h0, 32'h0});

        mem_a = 32'h0000_0080;
        single(1'b0, 8'h21, 2'b00, 1'b1, 32'h0, 32'h0, '{1'b0, 32'hFFFF_FF80, 32'h0});
        single(1'b0, 8'h21, 2'b00, 1'b0, 32'h0, 32'h0, '{1'b0, 32'h0000_0080, 32'h0});

        mem_a = 32'h1234_8001;
        single(1'b0, 8'h22, 2'b01, 1'b1, 32'h0, 32'h0, '{1'b0, 32'hFFFF_8001, 32'h0});
        single(1'b0, 8'h22, 2'b01, 1'b0, 32'h0, 32'h0, '{1'b0, 32'h0000_8001, 32'h0});

        single(1'b1, 8'h33, 2'b00, 1'b0, 32'hAABB_CCDD, 32'h0000_00DD, '{1'b0, 32'h0000_8001, 32'h0});
        single(1'b1, 8'h34, 2'b01, 1'b1, 32'hAABB_CCDD, 32'h0000_CCDD, '{1'b0, 32'h0000_8001, 32'h0});

        mem_a = 32'h8000_0000;
        single(1'b0, 8'h44, 2'b10, 1'b1, 32'h0, 32'h0, '{1'b0, 32'h8000_0000, 32'h0});

        // Doubleword load wrapping past 0xFF.
        mem_a = 32'h1111_2222; mem_b = 32'h3333_4444;
        sb.push_back('{1'b0, 32'h3333_4444, 32'h1111_2222});
        issue(1'b0, 8'hFE, 2'b11, 1'b0, 32'h0, 32'h0);
        chk("dwl_addr_b0", Address, 32'hFE);
        chk("dwl_datatype", DataType, 2);
        step(2);
        chk("dwl_release_mov", MOV, 0);
        chk("dwl_release_busy", Busy, 1);
        chk("dwl_release_done", Done, 0);
        step(1);
        chk("dwl_addr_b1", Address, 32'h02);
        chk("dwl_mov_b1", MOV, 1);
        step(2);
        chk("dwl_done_c6", Done, 1);
        step(1);

        // Doubleword store: high word first at Addr, low word at Addr+4.
        sb.push_back('{1'b0, 32'h3333_4444, 32'h1111_2222});
        issue(1'b1, 8'h40, 2'b11, 1'b0, 32'h0123_4567, 32'hCAFE_F00D);
        chk("dws_mdi_b0", MemDataIn, 32'hCAFE_F00D);
        chk("dws_rw", ReadWrite, 0);
        step(3);
        chk("dws_addr_b1", Address, 32'h44);
        chk("dws_mdi_b1", MemDataIn, 32'h0123_4567);
        step(2);
        chk("dws_done_c6", Done, 1);
        step(1);

        // Timeout: 15 WAIT cycles (2..16), Error in cycle 17.
        MOC = 1'b0;
        sb.push_back('{1'b1, 32'h3333_4444, 32'h1111_2222});
        issue(1'b0, 8'h50, 2'b10, 1'b0, 32'h0, 32'h0);
        step(15);
        chk("to_mov_c16", MOV, 1);
        chk("to_error_c16", Error, 0);
        step(1);
        chk("to_error_c17", Error, 1);
        chk("to_mov_c17", MOV, 0);
        step(1);
        chk("to_busy_c18", Busy, 0);
        chk("to_error_c18", Error, 0);
        MOC = 1'b1;

        // Start held high while busy and through the Done cycle is ignored.
        mem_a = 32'h5555_AAAA;
        sb.push_back('{1'b0, 32'h5555_AAAA, 32'h1111_2222});
        issue(1'b0, 8'h30, 2'b10, 1'b0, 32'h0, 32'h0);
        Start = 1'b1; Write = 1'b1; Addr = 8'h31;
        step(2);
        chk("bz_done_c3", Done, 1);
        step(1);
        Start = 1'b0;
        chk("bz_busy_c4", Busy, 0);
        chk("bz_mov_c4", MOV, 0);
        step(1);
        chk("bz_busy_c5", Busy, 0);

        // Reset during WAIT of a doubleword load, then a normal load.
        MOC = 1'b0;
        issue(1'b0, 8'h80, 2'b11, 1'b0, 32'h0, 32'h0);
        step(1);
        chk("rw_mov_wait", MOV, 1);
        Reset = 1'b1;
        step(1);
        chk_reset();
        Reset = 1'b0;
        MOC = 1'b1;
        mem_a = 32'h0BAD_CAFE;
        single(1'b0, 8'h08, 2'b10, 1'b0, 32'h0, 32'h0, '{1'b0, 32'h0BAD_CAFE, 32'h0});

        // Reset wins over a Start in the same cycle.
        Write = 1'b0; Addr = 8'h12; Size = 2'b10;
        Reset = 1'b1; Start = 1'b1;
        step(1);
        Reset = 1'b0; Start = 1'b0;
        chk("rs_busy", Busy, 0);
        chk("rs_mov", MOV, 0);
        step(1);
        chk("rs_busy_next", Busy, 0);
        chk("rs_mov_next", MOV, 0);

        step(3);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
